// File: rtl/lsu_dmem.sv
// lsu_dmem: dual-lane data-memory responder for the VLIW LSU.
//
// One shared word array with two combinational read ports and a single
// write port serves word loads and stores from two LSU lanes. Load data is
// registered and valid one cycle after the request. A one-entry store buffer
// absorbs the lane-1 half of a same-cycle dual store and drains on the next
// edge; busy asks the hazard unit to stall while that entry is occupied.
//
// Ports:
//   clk                  clock, rising edge
//   rst                  asynchronous reset, active-low
//   stall                pipeline stall from the hazard unit
//   wr_addr0/1           lane 0/1 store byte address (word index = addr[AW+1:2])
//   wr_data0/1           lane 0/1 store data
//   wr_en0/1             lane 0/1 store request
//   rd_addr0/1           lane 0/1 load byte address
//   rd_en0/1             lane 0/1 load request
//   rd_data0/1           lane 0/1 registered load data
//   busy                 combinational stall request to the hazard unit
//
// Request semantics: a bundle (loads and stores of both lanes) is accepted
// at a rising edge only when stall=0 and busy=0. Otherwise the whole bundle
// is dropped and the pipeline, which is holding, presents it again. The
// buffered store drains at the next edge unconditionally.
module lsu_dmem #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] wr_addr0,
   input  logic [31:0] wr_addr1,
   input  logic [31:0] wr_data0,
   input  logic [31:0] wr_data1,
   input  logic        wr_en0,
   input  logic        wr_en1,
   input  logic [31:0] rd_addr0,
   input  logic [31:0] rd_addr1,
   input  logic        rd_en0,
   input  logic        rd_en1,
   output logic [31:0] rd_data0,
   output logic [31:0] rd_data1,
   output logic        busy
);

   logic [31:0]   mem [DEPTH_WORDS];

   logic          pend_v;
   logic [AW-1:0] pend_idx;
   logic [31:0]   pend_data;

   logic [AW-1:0] wr_idx0;
   logic [AW-1:0] wr_idx1;
   logic [AW-1:0] rd_idx0;
   logic [AW-1:0] rd_idx1;

   logic          accept;
   logic          dual;
   logic          mem_we;
   logic [AW-1:0] mem_widx;
   logic [31:0]   mem_wdata;
   logic [31:0]   rd_val0;
   logic [31:0]   rd_val1;

   // Byte offset and bits above the array are intentionally ignored:
   // addresses wrap modulo DEPTH_WORDS.
   logic          unused_addr_bits;
   assign unused_addr_bits = ^{wr_addr0[31:AW+2], wr_addr0[1:0],
                               wr_addr1[31:AW+2], wr_addr1[1:0],
                               rd_addr0[31:AW+2], rd_addr0[1:0],
                               rd_addr1[31:AW+2], rd_addr1[1:0]};

   assign wr_idx0 = wr_addr0[AW+1:2];
   assign wr_idx1 = wr_addr1[AW+1:2];
   assign rd_idx0 = rd_addr0[AW+1:2];
   assign rd_idx1 = rd_addr1[AW+1:2];

   // No path from stall or from any registered output.
   assign busy   = pend_v && (wr_en0 || wr_en1);
   assign accept = !stall && !busy;
   assign dual   = accept && wr_en0 && wr_en1;

   // Single write port. A draining entry can never coincide with an accepted
   // store because busy blocks acceptance whenever pend_v and a store exist.
   always_comb begin
      mem_we    = 1'b0;
      mem_widx  = '0;
      mem_wdata = '0;
      if (pend_v) begin
         mem_we    = 1'b1;
         mem_widx  = pend_idx;
         mem_wdata = pend_data;
      end else if (accept && wr_en0) begin
         mem_we    = 1'b1;
         mem_widx  = wr_idx0;
         mem_wdata = wr_data0;
      end else if (accept && wr_en1) begin
         mem_we    = 1'b1;
         mem_widx  = wr_idx1;
         mem_wdata = wr_data1;
      end
   end

   // Array contents are not reset, but nothing is written while in reset.
   always_ff @(posedge clk) begin
      if (rst && mem_we) begin
         mem[mem_widx] <= mem_wdata;
      end
   end

   // Lane 1 of a dual store is parked here; landing one edge after lane 0
   // makes lane 1 win when both lanes target the same word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_v    <= 1'b0;
         pend_idx  <= '0;
         pend_data <= '0;
      end else begin
         pend_v <= dual;
         if (dual) begin
            pend_idx  <= wr_idx1;
            pend_data <= wr_data1;
         end
      end
   end

   // The parked store is not yet in the array, so loads of its word are
   // forwarded. Array reads see pre-edge contents, so a store accepted at
   // the same edge is never observed.
   assign rd_val0 = (pend_v && (pend_idx == rd_idx0)) ? pend_data : mem[rd_idx0];
   assign rd_val1 = (pend_v && (pend_idx == rd_idx1)) ? pend_data : mem[rd_idx1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data0 <= '0;
         rd_data1 <= '0;
      end else begin
         if (accept && rd_en0) begin
            rd_data0 <= rd_val0;
         end
         if (accept && rd_en1) begin
            rd_data1 <= rd_val1;
         end
      end
   end

endmodule
